// File: rtl/countdown_load_7bits.sv
// Loadable down-counter with IDLE/RUN/DONE sequencing and a one-cycle done pulse.
// Optional periodic mode: define COUNTDOWN_AUTO_RELOAD_EN to restart from the last loaded value.
//
// state | meaning
// IDLE  | waiting for a load; load_ready high
// RUN   | counting down on count_enb; busy high
// DONE  | terminal cycle; done high for exactly this cycle
module countdown_load_7bits #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load,
    output logic             load_ready,
    input  logic             count_enb,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_nxt;
    logic             load_accept;

    // abort in IDLE blocks a simultaneous load
    assign load_accept = (state == IDLE) && load && !abort;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reload <= '0;
        end else if (load_accept) begin
            reload <= load_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count_q <= '0;
        end else begin
            state   <= state_nxt;
            count_q <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count_q;
        case (state)
            IDLE: begin
                if (load_accept) begin
                    count_nxt = load_data;
                    state_nxt = (load_data == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (count_enb) begin
                    // count==0 cannot occur in RUN, but treat it like 1 so it never wraps
                    if (count_q > WIDTH'(1)) begin
                        count_nxt = count_q - WIDTH'(1);
                    end else begin
                        count_nxt = '0;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    if (reload != '0) begin
                        state_nxt = RUN;
                        count_nxt = reload;
                    end else begin
                        state_nxt = IDLE;
                    end
`else
                    state_nxt = IDLE;
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // status flags come from registers only, never straight from inputs
    always_comb begin
        load_ready = (state == IDLE);
        busy       = (state == RUN);
        done       = (state == DONE);
        count      = count_q;
        zero       = (count_q == '0);
    end

endmodule

// File: tb/tb_countdown_load_7bits.sv
// Self-checking bench for countdown_load_7bits: vector table plus multi-cycle corner sequences.
// Expectations for the periodic mode apply when COUNTDOWN_AUTO_RELOAD_EN is defined.
module tb_countdown_load_7bits;

    logic       clk;
    logic       reset;
    logic [6:0] load_data;
    logic       load;
    logic       load_ready;
    logic       count_enb;
    logic       abort;
    logic [6:0] count;
    logic       busy;
    logic       done;
    logic       zero;

    int n_pass;
    int n_total;

    countdown_load_7bits #(.WIDTH(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_data  (load_data),
        .load       (load),
        .load_ready (load_ready),
        .count_enb  (count_enb),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .zero       (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       ld;
        logic [6:0] data;
        logic       enb;
        logic       ab;
        logic [6:0] c;
        logic       b;
        logic       d;
        logic       r;
        logic       z;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [6:0] data, input logic enb, input logic ab);
        load      = ld;
        load_data = data;
        count_enb = enb;
        abort     = ab;
    endtask

    task automatic check_all(input string tag, input logic [6:0] c, input logic b,
                             input logic d, input logic r, input logic z);
        check({tag, "_count"}, int'(count), int'(c));
        check({tag, "_busy"}, int'(busy), int'(b));
        check({tag, "_done"}, int'(done), int'(d));
        check({tag, "_ready"}, int'(load_ready), int'(r));
        check({tag, "_zero"}, int'(zero), int'(z));
    endtask

    initial begin
        int         edges;
        int         exp_c;
        int         diverged;
        logic       enb_now;

        n_pass  = 0;
        n_total = 0;

        //               ld    data    enb   ab    count  busy  done  rdy   zero
        vecs[0]  = '{1'b1, 7'd5,  1'b1, 1'b0, 7'd5,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 7'd0,  1'b1, 1'b0, 7'd4,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 7'd0,  1'b1, 1'b0, 7'd3,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 7'd0,  1'b1, 1'b0, 7'd2,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 7'd0,  1'b1, 1'b0, 7'd1,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 7'd0,  1'b1, 1'b0, 7'd0,  1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 7'd0,  1'b1, 1'b1, 7'd0,  1'b0, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 7'd0,  1'b0, 1'b0, 7'd0,  1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 7'd0,  1'b0, 1'b0, 7'd0,  1'b0, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 7'd10, 1'b0, 1'b0, 7'd10, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 7'd3,  1'b0, 1'b0, 7'd10, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 7'd0,  1'b1, 1'b0, 7'd9,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 7'd2,  1'b1, 1'b1, 7'd9,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 7'd7,  1'b0, 1'b1, 7'd9,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 7'd1,  1'b0, 1'b0, 7'd1,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 7'd0,  1'b1, 1'b0, 7'd0,  1'b0, 1'b1, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 7'd0,  1'b1, 1'b1, 7'd0,  1'b0, 1'b0, 1'b1, 1'b1};

        drive(1'b0, 7'd0, 1'b0, 1'b0);
        reset = 1'b0;
        #12;
        check_all("reset", 7'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].ld, vecs[i].data, vecs[i].enb, vecs[i].ab);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].c, vecs[i].b, vecs[i].d, vecs[i].r, vecs[i].z);
        end

        // asynchronous reset in the middle of a run, between edges
        drive(1'b1, 7'd30, 1'b1, 1'b0);
        tick();
        drive(1'b0, 7'd0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        drive(1'b0, 7'd0, 1'b0, 1'b0);
        check("pre_reset_count", int'(count), 20);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_reset", 7'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 7'd6, 1'b0, 1'b0);
        tick();
        check("first_load_after_reset", int'(count), 6);
        check("first_load_busy", int'(busy), 1);
        drive(1'b0, 7'd0, 1'b0, 1'b1);
        tick();
        check("abort_idle_ready", int'(load_ready), 1);

        // 127 with count_enb toggling, starting low; stray loads during RUN
        drive(1'b1, 7'd127, 1'b0, 1'b0);
        tick();
        check("load127_count", int'(count), 127);
        edges    = 0;
        exp_c    = 127;
        diverged = 0;
        while (edges < 400) begin
            edges++;
            enb_now = (edges % 2 == 0);
            drive((edges % 2 == 1), 7'd5, enb_now, 1'b0);
            tick();
            if (enb_now && exp_c > 0) exp_c--;
            if (int'(count) != exp_c && diverged == 0) diverged = edges;
            if (done) break;
        end
        check("toggle_edges_to_done", edges, 254);
        check("toggle_count_divergence_edge", diverged, 0);
        check("toggle_final_zero", int'(zero), 1);
        drive(1'b0, 7'd0, 1'b0, 1'b1);
        tick();
        check("toggle_abort_ready", int'(load_ready), 1);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        begin
            logic [6:0] exp_seq[8];
            exp_seq[0] = 7'd3; exp_seq[1] = 7'd2; exp_seq[2] = 7'd1; exp_seq[3] = 7'd0;
            exp_seq[4] = 7'd3; exp_seq[5] = 7'd2; exp_seq[6] = 7'd1; exp_seq[7] = 7'd0;
            drive(1'b1, 7'd3, 1'b1, 1'b0);
            tick();
            drive(1'b0, 7'd0, 1'b1, 1'b0);
            for (int i = 0; i < 8; i++) begin
                check($sformatf("reload_count%0d", i), int'(count), int'(exp_seq[i]));
                check($sformatf("reload_done%0d", i), int'(done), (i % 4 == 3) ? 1 : 0);
                if (i < 7) tick();
            end
            drive(1'b0, 7'd0, 1'b1, 1'b1);
            tick();
            check("reload_abort_ready", int'(load_ready), 1);
            check("reload_abort_busy", int'(busy), 0);
        end
`else
        drive(1'b1, 7'd2, 1'b1, 1'b0);
        tick();
        drive(1'b0, 7'd0, 1'b1, 1'b0);
        tick();
        check("oneshot_count1", int'(count), 1);
        tick();
        check("oneshot_done", int'(done), 1);
        tick();
        check("oneshot_back_idle", int'(load_ready), 1);
        check("oneshot_not_busy", int'(busy), 0);
        check("oneshot_done_low", int'(done), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/countdown_load_7bits.md
COUNTDOWN_LOAD_7BITS -- requirements
Module: countdown_load_7bits

Interface
REQ-001 SHALL have parameter: WIDTH, 7, bit width of load_data, count and reload register.
REQ-002 SHALL have port: clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: load_data  input  WIDTH  start value, typically a register_7bits q.
REQ-005 SHALL have port: load  input  1  load request, accepted only when load_ready=1.
REQ-006 SHALL have port: load_ready  output  1  high in IDLE only.
REQ-007 SHALL have port: count_enb  input  1  decrement enable.
REQ-008 SHALL have port: abort  input  1  synchronous cancel.
REQ-009 SHALL have port: count  output  WIDTH  current down-count value.
REQ-010 SHALL have port: busy  output  1  high in RUN.
REQ-011 SHALL have port: done  output  1  single-cycle terminal pulse.
REQ-012 SHALL have port: zero  output  1  count==0.

Function
REQ-013 SHALL implement three states: IDLE, RUN, DONE.
REQ-014 SHALL treat a load as accepted on a rising edge with load=1 and load_ready=1; count, state and reload register update on that edge (latency 1).
REQ-015 IDLE + accepted load, load_data!=0: count<=load_data, reload<=load_data, next RUN.
REQ-016 IDLE + accepted load, load_data==0: count<=0, reload<=0, next DONE.
REQ-017 RUN + count_enb=1 + count>1: count<=count-1, stay RUN.
REQ-018 RUN + count_enb=1 + count==1: count<=0, next DONE.
REQ-019 RUN + count_enb=0: count and state hold.
REQ-020 DONE: done=1 for exactly that cycle, load_ready=0; next state per REQ-027/028.
REQ-021 load SHALL be ignored (no side effect) outside IDLE.
REQ-022 abort=1 in RUN or DONE: next IDLE, count holds, done suppressed on the following cycle.
REQ-023 abort SHALL take priority over load and count_enb on the same edge; abort in IDLE has no effect and blocks a simultaneous load.
REQ-024 count SHALL never wrap below 0; count_enb while count==0 leaves count 0.
REQ-025 busy, done, load_ready SHALL decode from the state register only (no input-to-output combinational path); zero decodes from count.

Reset
REQ-026 reset=0 SHALL immediately force state IDLE, count=0, reload=0, so done=0, busy=0, zero=1, load_ready=1, including mid-RUN; the first load is accepted on the first rising edge after reset release.

Configuration
REQ-027 Macro COUNTDOWN_AUTO_RELOAD_EN defined: DONE with reload!=0 and abort=0 SHALL next go to RUN with count<=reload (periodic done every reload count-enabled cycles plus 1); DONE with reload==0 goes to IDLE.
REQ-028 Macro COUNTDOWN_AUTO_RELOAD_EN undefined: DONE SHALL always go to IDLE; reload register may be omitted by synthesis.

Verification
REQ-029 Load 7'd5, count_enb=1 constant -> count 5,4,3,2,1,0 on successive edges; done high exactly one cycle when count=0; busy low after that cycle; load_ready back high next cycle.
REQ-030 Load 7'd0 -> DONE next edge, done one cycle, count stays 0, busy never high.
REQ-031 Load 7'd127, count_enb toggled 1/0 each cycle -> done after 254 edges from RUN entry; load pulses during RUN leave count unchanged.
REQ-032 Load 7'd10, abort at count=4 -> IDLE, count held 4, no done pulse; abort+load same edge in IDLE -> no load.
REQ-033 reset driven 0 mid-RUN between edges at count=20 -> count 0, busy 0, zero 1 immediately without clock edge.
REQ-034 With COUNTDOWN_AUTO_RELOAD_EN, load 7'd3, count_enb=1 -> done every 4 cycles, count sequence 3,2,1,0,3,2,1,0...; abort during DONE -> IDLE.
